// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard / forwarding controller.
// Forward-select encodings, FSM state enum and the scoreboard slot record live here.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FREEZE = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_rs;
        logic             use_rt;
    } slot_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One EX-operand forward select: EX/MEM result first, then MEM/WB, else register file.
// Loads sitting in EX/MEM have no data yet, so they are never a MEM-stage source.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic             i_mem_valid,
    input  logic             i_mem_regwrite,
    input  logic             i_mem_memread,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_wb_valid,
    input  logic             i_wb_regwrite,
    input  logic [REG_W-1:0] i_wb_dst,
    input  logic [REG_W-1:0] i_src,
    input  logic             i_use_src,
    output logic [1:0]       o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_valid && i_mem_regwrite && !i_mem_memread &&
                       (i_mem_dst != REG_ZERO) && (i_mem_dst == i_src) && i_use_src;
    assign w_wb_hit  = i_wb_valid && i_wb_regwrite &&
                       (i_wb_dst != REG_ZERO) && (i_wb_dst == i_src) && i_use_src;

    always_comb begin
        o_sel = FWD_RF;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, redirect flush,
// data-memory freeze, EX operand forwarding and saturating event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [REG_W-1:0] id_dst_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             ex_redirect_i,
    input  logic             dm_wait_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_we_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    state_t           r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    slot_t w_id_slot;
    logic  w_hit_rs;
    logic  w_hit_rt;
    logic  w_lu;
    logic  w_freeze;
    logic  w_redirect;
    logic  w_lu_stall;
    logic  w_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    assign w_id_slot = {1'b1, id_regwrite_i, id_memread_i, id_dst_i,
                        id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i};

    assign w_hit_rs   = id_use_rs_i && (r_ex.dst == id_rs_i);
    assign w_hit_rt   = id_use_rt_i && (r_ex.dst == id_rt_i);
    assign w_lu       = r_ex.valid && r_ex.memread && (r_ex.dst != REG_ZERO) &&
                        id_valid_i && (w_hit_rs || w_hit_rt);
    assign w_freeze   = dm_wait_i;
    assign w_redirect = ex_redirect_i && !w_freeze;
    assign w_lu_stall = w_lu && !w_freeze && !ex_redirect_i;

    // Scoreboard fields kept for completeness but not consumed downstream.
    assign w_unused = ^{r_ex.regwrite, r_mem.rs, r_mem.rt, r_mem.use_rs, r_mem.use_rt,
                        r_wb.memread, r_wb.rs, r_wb.rt, r_wb.use_rs, r_wb.use_rt};

    // Freeze beats redirect beats load-use; reset forces the free-running pattern.
    always_comb begin
        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_we_o     = 1'b1;
        if (!rst_i) begin
            if (w_freeze) begin
                pc_we_o   = 1'b0;
                ifid_we_o = 1'b0;
                pipe_we_o = 1'b0;
            end else if (ex_redirect_i) begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end else if (w_lu) begin
                pc_we_o       = 1'b0;
                ifid_we_o     = 1'b0;
                idex_bubble_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (pipe_we_o) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= (idex_bubble_o || !id_valid_i) ? slot_t'('0) : w_id_slot;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:    if (dm_wait_i)  r_state <= ST_FREEZE;
                ST_FREEZE: if (!dm_wait_i) r_state <= ST_RUN;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= sat_inc(r_stall_cnt, w_freeze || w_lu_stall);
            r_flush_cnt <= sat_inc(r_flush_cnt, w_redirect);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    hazard_fwd_sel u_fwd_a (
        .i_mem_valid    (r_mem.valid),
        .i_mem_regwrite (r_mem.regwrite),
        .i_mem_memread  (r_mem.memread),
        .i_mem_dst      (r_mem.dst),
        .i_wb_valid     (r_wb.valid),
        .i_wb_regwrite  (r_wb.regwrite),
        .i_wb_dst       (r_wb.dst),
        .i_src          (r_ex.rs),
        .i_use_src      (r_ex.use_rs),
        .o_sel          (fwd_a_o)
    );

    hazard_fwd_sel u_fwd_b (
        .i_mem_valid    (r_mem.valid),
        .i_mem_regwrite (r_mem.regwrite),
        .i_mem_memread  (r_mem.memread),
        .i_mem_dst      (r_mem.dst),
        .i_wb_valid     (r_wb.valid),
        .i_wb_regwrite  (r_wb.regwrite),
        .i_wb_dst       (r_wb.dst),
        .i_src          (r_ex.rt),
        .i_use_src      (r_ex.use_rt),
        .o_sel          (fwd_b_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stalls, forwarding, redirect, freeze,
// counter saturation and asynchronous reset.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        id_use_rs_i;
    logic        id_use_rt_i;
    logic [4:0]  id_dst_i;
    logic        id_regwrite_i;
    logic        id_memread_i;
    logic        ex_redirect_i;
    logic        dm_wait_i;
    logic        pc_we_o;
    logic        ifid_we_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic        pipe_we_o;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    logic [4:0]  ctl;
    int          n_vec  = 0;
    int          n_fail = 0;

    // ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we}
    localparam logic [4:0] CTL_RUN    = 5'b11001;
    localparam logic [4:0] CTL_LU     = 5'b00011;
    localparam logic [4:0] CTL_REDIR  = 5'b11111;
    localparam logic [4:0] CTL_FREEZE = 5'b00000;

    assign ctl = {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, pipe_we_o};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_use_rs_i   (id_use_rs_i),
        .id_use_rt_i   (id_use_rt_i),
        .id_dst_i      (id_dst_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .ex_redirect_i (ex_redirect_i),
        .dm_wait_i     (dm_wait_i),
        .pc_we_o       (pc_we_o),
        .ifid_we_o     (ifid_we_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_bubble_o (idex_bubble_o),
        .pipe_we_o     (pipe_we_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] dst, input logic rw, input logic mr);
        id_valid_i    = 1'b1;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_use_rs_i   = urs;
        id_use_rt_i   = urt;
        id_dst_i      = dst;
        id_regwrite_i = rw;
        id_memread_i  = mr;
    endtask

    task automatic idle_id();
        id_valid_i    = 1'b0;
        id_rs_i       = 5'd0;
        id_rt_i       = 5'd0;
        id_use_rs_i   = 1'b0;
        id_use_rt_i   = 1'b0;
        id_dst_i      = 5'd0;
        id_regwrite_i = 1'b0;
        id_memread_i  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        ex_redirect_i = 1'b0;
        dm_wait_i     = 1'b0;
        idle_id();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i         = 1'b1;
        ex_redirect_i = 1'b1;
        dm_wait_i     = 1'b1;
        set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_RUN); end
        n_vec++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got %b want 0000", {fwd_a_o, fwd_b_o}); end
        n_vec++;
        if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt got %h/%h want 0000/0000", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);   // lw $2,0($1)
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_lw_ctl got %b want %b", ctl, CTL_RUN); end
        tick();
        set_id(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$2,$4
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_LU) begin n_fail++; $display("FAIL lu_stall_ctl got %b want %b", ctl, CTL_LU); end
        tick();
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_one_cycle got %b want %b", ctl, CTL_RUN); end
        n_vec++;
        if (stall_cnt_o !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt_o); end
        tick();
        idle_id();
        @(negedge clk);
        n_vec++;
        if (fwd_a_o !== 2'b01 || fwd_b_o !== 2'b00) begin
            n_fail++; $display("FAIL lu_fwd got %b/%b want 01/00", fwd_a_o, fwd_b_o);
        end
    endtask

    task automatic test_ex_mem_fwd();
        do_reset();
        set_id(5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);   // add $2,$1,$1
        tick();
        set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // sub $5,$2,$2
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL alu_nostall got %b want %b", ctl, CTL_RUN); end
        tick();
        idle_id();
        @(negedge clk);
        n_vec++;
        if (fwd_a_o !== 2'b10 || fwd_b_o !== 2'b10) begin
            n_fail++; $display("FAIL alu_fwd got %b/%b want 10/10", fwd_a_o, fwd_b_o);
        end
        n_vec++;
        if (stall_cnt_o !== 16'd0) begin n_fail++; $display("FAIL alu_stall_cnt got %0d want 0", stall_cnt_o); end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        set_id(5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);   // add $2,$1,$1
        tick();
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);   // add $2,$3,$3
        tick();
        set_id(5'd2, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add $6,$2,$0
        tick();
        idle_id();
        @(negedge clk);
        n_vec++;
        if (fwd_a_o !== 2'b10 || fwd_b_o !== 2'b00) begin
            n_fail++; $display("FAIL prio_fwd got %b/%b want 10/00", fwd_a_o, fwd_b_o);
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw $0,0($1)
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$0,$0
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL r0_nostall got %b want %b", ctl, CTL_RUN); end
        tick();
        idle_id();
        @(negedge clk);
        n_vec++;
        if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin
            n_fail++; $display("FAIL r0_fwd got %b/%b want 00/00", fwd_a_o, fwd_b_o);
        end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);   // lw $2
        tick();
        set_id(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        ex_redirect_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_REDIR) begin n_fail++; $display("FAIL redir_ctl got %b want %b", ctl, CTL_REDIR); end
        tick();
        ex_redirect_i = 1'b0;
        idle_id();
        @(negedge clk);
        n_vec++;
        if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL redir_cnt got %0d/%0d want 1/0", flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);   // lw $2
        tick();
        set_id(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$2,$4
        dm_wait_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (ctl !== CTL_FREEZE) begin n_fail++; $display("FAIL frz_ctl[%0d] got %b want %b", i, ctl, CTL_FREEZE); end
            tick();
        end
        dm_wait_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_LU) begin n_fail++; $display("FAIL frz_then_lu got %b want %b", ctl, CTL_LU); end
        tick();
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL frz_release got %b want %b", ctl, CTL_RUN); end
        n_vec++;
        if (stall_cnt_o !== 16'd4) begin n_fail++; $display("FAIL frz_stall_cnt got %0d want 4", stall_cnt_o); end
    endtask

    task automatic test_freeze_redirect();
        do_reset();
        dm_wait_i     = 1'b1;
        ex_redirect_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_FREEZE) begin n_fail++; $display("FAIL frzrd_ctl got %b want %b", ctl, CTL_FREEZE); end
        tick();
        dm_wait_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_REDIR) begin n_fail++; $display("FAIL frzrd_after got %b want %b", ctl, CTL_REDIR); end
        tick();
        ex_redirect_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd1) begin
            n_fail++; $display("FAIL frzrd_cnt got %0d/%0d want 1/1", flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        dm_wait_i = 1'b1;
        repeat (65535) tick();
        @(negedge clk);
        n_vec++;
        if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_fill got %h want FFFF", stall_cnt_o); end
        tick();
        @(negedge clk);
        n_vec++;
        if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_frz_hold got %h want FFFF", stall_cnt_o); end
        dm_wait_i = 1'b0;
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);   // lw $2
        tick();
        set_id(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // lu stall
        tick();
        @(negedge clk);
        n_vec++;
        if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_lu_hold got %h want FFFF", stall_cnt_o); end
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7
        tick();
        set_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);   // uses $7
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_LU) begin n_fail++; $display("FAIL sat_pre_rst got %b want %b", ctl, CTL_LU); end
        rst_i = 1'b1;
        #1;
        n_vec++;
        if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL rst_async_cnt got %h/%h want 0000/0000", stall_cnt_o, flush_cnt_o);
        end
        n_vec++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL rst_async_ctl got %b want %b", ctl, CTL_RUN); end
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL rst_no_pending got %b want %b", ctl, CTL_RUN); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_ex_mem_fwd();
        test_fwd_priority();
        test_reg_zero();
        test_redirect_priority();
        test_freeze();
        test_freeze_redirect();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
